// File: rtl/exe_branch_unit_pkg.sv
// Shared processor definitions used by the execute-stage branch resolver.
package exe_branch_unit_pkg;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  localparam int unsigned BRANCH_OFFSET_SHIFT = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } branch_state_e;

endpackage : exe_branch_unit_pkg

// File: rtl/exe_branch_unit_if.sv
// EXE-stage branch/status bundle: ID/EXE fields and ALU flags in, resolver results out.
interface exe_branch_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             b;
  logic             s;
  logic [31:0]      pc;
  logic [23:0]      imm_signed_24;
  logic [3:0]       alu_status;
  logic             branch_taken;
  logic [31:0]      branch_addr;
  logic             flush;
  logic [3:0]       status;
  logic [CNT_W-1:0] branch_count;

  modport master (
    output b, s, pc, imm_signed_24, alu_status,
    input  branch_taken, branch_addr, flush, status, branch_count
  );

  modport slave (
    input  b, s, pc, imm_signed_24, alu_status,
    output branch_taken, branch_addr, flush, status, branch_count
  );
endinterface : exe_branch_unit_if

// File: rtl/exe_branch_unit_status_register.sv
// 4-bit flag register with write enable; reusable by any flag-holding stage.
module status_register (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  logic [3:0] flags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else if (we_i) begin
      flags_q <= d_i;
    end
  end

  assign q_o = flags_q;
endmodule : status_register

// File: rtl/exe_branch_unit.sv
// Execute-stage branch resolver: target adder, squash-window FSM, NZCV owner, taken-branch counter.
module exe_branch_unit
  import exe_branch_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  exe_branch_unit_if.slave  bus
);
  localparam logic [3:0] SQUASH_INIT = 4'(FLUSH_CYCLES - 1);

  branch_state_e    state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             in_squash;
  logic [31:0]      offset;
  logic [3:0]       status_q;

  assign offset           = 32'(signed'(bus.imm_signed_24)) << BRANCH_OFFSET_SHIFT;
  assign bus.branch_addr  = bus.pc + offset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    in_squash = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.b) begin
          accept = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = SQUASH;
            cnt_d   = SQUASH_INIT;
          end
        end
      end
      SQUASH: begin
        in_squash = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with rst so a held reset never leaks a combinational branch/flush.
  assign bus.branch_taken = rst & accept;
  assign bus.flush        = rst & (accept | in_squash);

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign bus.branch_count = count_q;

  status_register u_status (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   ((state_q == IDLE) && bus.s),
    .d_i    (bus.alu_status),
    .q_o    (status_q)
  );

  assign bus.status = status_q;
endmodule : exe_branch_unit

// File: doc/exe_branch_unit.md
# exe_branch_unit

Execute-stage branch resolver and status-register owner for the 5-stage ARM pipeline. It consumes the `b`, `s`, `pc` and `imm_signed_24` fields delivered by the ID/EXE pipeline register and the NZCV flags from the ALU. It computes the branch target, drives `flush` back to the IF and ID pipeline registers for a programmable squash window, and holds the architectural NZCV status register read by the ID-stage condition check.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles `flush` stays high per taken branch; legal range 1..15.
- `CNT_W`, default 16: width of the taken-branch performance counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `b`  in  1  branch instruction in EXE, from the ID/EXE register.
- `s`  in  1  status-update request in EXE, from the ID/EXE register.
- `pc`  in  32  PC value carried with the EXE instruction.
- `imm_signed_24`  in  24  signed word offset of the branch.
- `alu_status`  in  4  ALU flags {N,Z,C,V} for the current EXE instruction.
- `branch_taken`  out  1  selects `branch_addr` at the IF PC mux.
- `branch_addr`  out  32  branch target.
- `flush`  out  1  squash to the IF/ID and ID/EXE registers.
- `status`  out  4  registered NZCV, read by ID.
- `branch_count`  out  CNT_W  saturating count of accepted taken branches.

## Operation
- `branch_addr` = `pc` + (sign_extend(`imm_signed_24`) << 2). The sum is 32-bit modulo with no overflow detection. The output is combinational and valid every cycle.
- FSM has two states, IDLE and SQUASH. Reset state is IDLE.
- In IDLE with `b`=1:
  - `branch_taken`=1 and `flush`=1 in the same cycle (combinational).
  - `branch_count` increments at the edge.
  - If `FLUSH_CYCLES`>1, the FSM moves to SQUASH and the squash counter loads `FLUSH_CYCLES`-1. Otherwise it stays in IDLE.
- In SQUASH:
  - `flush`=1 and `branch_taken`=0.
  - The counter decrements each cycle. When the counter is 1, the next state is IDLE.
  - `b` and `s` are ignored, since they belong to wrong-path instructions.
- Status register:
  - In IDLE with `s`=1, `status` <= `alu_status` at the edge.
  - If `b` and `s` are both 1 in IDLE, both actions happen.
  - Otherwise `status` holds its value.
- `branch_count` saturates at all-ones and does not wrap.
- Reset values: `status`=0, `branch_count`=0, FSM=IDLE, squash counter=0. During reset, `flush`=0 and `branch_taken`=0.

## Timing
- Branch resolution has 0-cycle latency: `branch_taken`, `branch_addr` and the first `flush` cycle appear in the same cycle as `b`. IF loads the target at the following edge.
- `flush` is high for exactly `FLUSH_CYCLES` consecutive cycles per accepted branch.
- A new branch can be accepted one cycle after `flush` falls, or back-to-back when `FLUSH_CYCLES`=1.
- `status` reflects an `s` instruction from the cycle after its edge. ID sees the updated flags one cycle later.
- Assertion of `rst` mid-SQUASH forces IDLE asynchronously: `flush` drops immediately and the pending squash cycles are discarded.
- Release of `rst` is synchronised externally. The first edge after release behaves as IDLE.

## Structure
- The shared processor package holds:
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0);
  - the FSM state typedef {IDLE, SQUASH};
  - the `BRANCH_OFFSET_SHIFT`=2 constant.
- The `status_register` sub-module is a 4-bit register with async active-low reset and a write enable. It is reused by any future flag-holding stage.
- FSM, squash counter, adder and perf counter live in the top module.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles, release, apply no stimulus. Required response: `flush`=0, `branch_taken`=0, `status`=0000, `branch_count`=0.
- Forward branch: `pc`=0x0000_0100, `imm_signed_24`=0x000004, `b`=1 for one cycle. Required response: `branch_addr`=0x0000_0110, `branch_taken`=1 and `flush`=1 that cycle, `branch_count`=1 after.
- Backward branch with wrap: `pc`=0x0000_0004, `imm_signed_24`=0xFFFFFE. Required response: `branch_addr`=0xFFFF_FFFC.
- Squash window with `FLUSH_CYCLES`=3: branch, then `b`=1 and `s`=1 with `alu_status`=1010 in the next two cycles. Required response:
  - `flush` high exactly 3 cycles and `branch_taken` high only the first;
  - `status` unchanged and `branch_count`=1.
- Simultaneous b+s in IDLE: `alu_status`=0110. Required response: `status`=0110 next cycle and the branch is taken. Then `s`=1 alone with `alu_status`=1001 gives `status`=1001.
- Reset mid-squash and saturation:
  - With `FLUSH_CYCLES`=4, assert `rst` in the 2nd squash cycle. Required response: `flush` drops without waiting for an edge.
  - With `CNT_W`=2, apply 5 branches. Required response: `branch_count`=3.
